board_painter: RTL

//  Reader side of the 512-bit game board bus: snapshots board, pointer and gaming_status on request.

---
 rtl/board_painter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/board_painter.sv
// board_painter: reader side of the 512-bit game board bus.
// Snapshots board, pointer and game status on a start request, then rasterises
// the 16x16 cell grid into one registered VGA pixel write per clock.
// Optional feature macro: BOARD_PAINTER_GRID_EN draws grid lines on the last
// pixel row/column of every cell. The pixel count and timing are the same in both builds.
module board_painter #(
    parameter int         CELL_PX   = 7,
    parameter int         ORIGIN_X  = 24,
    parameter int         ORIGIN_Y  = 4,
    parameter logic [2:0] COL_EMPTY = 3'b110,
    parameter logic [2:0] COL_A     = 3'b000,
    parameter logic [2:0] COL_B     = 3'b111,
    parameter logic [2:0] COL_PTR   = 3'b100,
    parameter logic [2:0] COL_GRID  = 3'b010
) (
    input  logic         Clck,
    input  logic         Reset,
    input  logic         start,
    input  logic [511:0] board,
    input  logic [3:0]   pointer_loc_x,
    input  logic [3:0]   pointer_loc_y,
    input  logic [1:0]   gaming_status,
    output logic [7:0]   vga_x,
    output logic [6:0]   vga_y,
    output logic [2:0]   vga_colour,
    output logic         vga_plot,
    output logic         busy,
    output logic         frame_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DRAW = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] SUB_LAST = 3'(CELL_PX - 1);
    localparam logic [7:0] X_START  = 8'(ORIGIN_X);
    localparam logic [6:0] Y_START  = 7'(ORIGIN_Y);

    state_t       r_state;

    // Frame snapshot, frozen for the whole frame
    logic [511:0] r_board;
    logic [3:0]   r_ptr_x;
    logic [3:0]   r_ptr_y;
    logic [1:0]   r_status;

    // Raster position: sub-pixel within cell, cell index, and screen accumulators
    logic [2:0]   r_sub_x;
    logic [2:0]   r_sub_y;
    logic [3:0]   r_cx;
    logic [3:0]   r_cy;
    logic [7:0]   r_px;
    logic [6:0]   r_py;

    logic [7:0]   r_vga_x;
    logic [6:0]   r_vga_y;
    logic [2:0]   r_vga_colour;
    logic         r_vga_plot;
    logic         r_busy;
    logic         r_frame_done;

    logic         w_sub_x_last;
    logic         w_sub_y_last;
    logic         w_cx_last;
    logic         w_cy_last;
    logic         w_last_pixel;
    logic         w_on_border;
    logic         w_is_ptr;
    logic [1:0]   w_cell;
    logic [2:0]   w_colour;

    assign w_sub_x_last = (r_sub_x == SUB_LAST);
    assign w_sub_y_last = (r_sub_y == SUB_LAST);
    assign w_cx_last    = (r_cx == 4'd15);
    assign w_cy_last    = (r_cy == 4'd15);
    assign w_last_pixel = w_sub_x_last & w_cx_last & w_sub_y_last & w_cy_last;

    // Cell (cx,cy) lives at bit cx*2 + cy*32, i.e. {cy,cx,0}
    assign w_cell = r_board[{r_cy, r_cx, 1'b0} +: 2];

    assign w_on_border = (r_sub_x == 3'd0) | w_sub_x_last | (r_sub_y == 3'd0) | w_sub_y_last;
    assign w_is_ptr    = (r_status == 2'b00) & (r_cx == r_ptr_x) & (r_cy == r_ptr_y) & w_on_border;

`ifndef BOARD_PAINTER_GRID_EN
    logic w_unused_grid;
    assign w_unused_grid = ^COL_GRID;
`endif

    // Pixel colour by priority: pointer outline, grid line, cell contents
    always_comb begin
        w_colour = COL_EMPTY;
        if (w_is_ptr) begin
            w_colour = COL_PTR;
        end
`ifdef BOARD_PAINTER_GRID_EN
        else if (w_sub_x_last | w_sub_y_last) begin
            w_colour = COL_GRID;
        end
`endif
        else begin
            case (w_cell)
                2'b01:   w_colour = COL_A;
                2'b10:   w_colour = COL_B;
                default: w_colour = COL_EMPTY;
            endcase
        end
    end

    // Frame sequencer: snapshot, raster walk and registered pixel outputs
    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_board      <= '0;
            r_ptr_x      <= '0;
            r_ptr_y      <= '0;
            r_status     <= '0;
            r_sub_x      <= '0;
            r_sub_y      <= '0;
            r_cx         <= '0;
            r_cy         <= '0;
            r_px         <= '0;
            r_py         <= '0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_vga_plot   <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_board  <= board;
                    r_ptr_x  <= pointer_loc_x;
                    r_ptr_y  <= pointer_loc_y;
                    r_status <= gaming_status;
                    r_sub_x  <= '0;
                    r_sub_y  <= '0;
                    r_cx     <= '0;
                    r_cy     <= '0;
                    r_px     <= X_START;
                    r_py     <= Y_START;
                    r_state  <= S_DRAW;
                end
                S_DRAW: begin
                    r_vga_x      <= r_px;
                    r_vga_y      <= r_py;
                    r_vga_colour <= w_colour;
                    r_vga_plot   <= 1'b1;
                    // Screen x just counts up along a row; wrap back at the row end
                    if (!w_sub_x_last) begin
                        r_sub_x <= r_sub_x + 3'd1;
                        r_px    <= r_px + 8'd1;
                    end else begin
                        r_sub_x <= '0;
                        if (!w_cx_last) begin
                            r_cx <= r_cx + 4'd1;
                            r_px <= r_px + 8'd1;
                        end else begin
                            r_cx <= '0;
                            r_px <= X_START;
                            r_py <= r_py + 7'd1;
                            if (!w_sub_y_last) begin
                                r_sub_y <= r_sub_y + 3'd1;
                            end else begin
                                r_sub_y <= '0;
                                r_cy    <= r_cy + 4'd1;
                            end
                        end
                    end
                    if (w_last_pixel) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;
    assign vga_plot   = r_vga_plot;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
